gpu_operand_collector: RTL and testbench
========================================

Name: gpu_operand_collector

Overview:
- Sits directly downstream of gpu_warp's decode stage and reads source register operands from the banked register file for one decoded instruction.
- Accepts up to two source register numbers per request.
- Maps each register to a single-ported bank and serialises bank conflicts.
- Presents both operands to the execute stage over a valid/ready handshake.

Parameters:
- NUM_BANKS, 4, number of single-ported register banks (power of two).
- REGS_PER_BANK, 16, rows per bank (power of two).
- DATA_W, 64, operand width in bits.
- WARP_ID_W, 5, warp identifier width.
- REG_W, derived as log2(NUM_BANKS*REGS_PER_BANK), register-number width (6 at defaults).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  decode presents a request.
- req_ready  out  1  collector can accept a request.
- req_warp  in  WARP_ID_W  warp number of the request.
- req_src1_en  in  1  operand 1 is a register read.
- req_src1_reg  in  REG_W  operand 1 register number.
- req_src2_en  in  1  operand 2 is a register read.
- req_src2_reg  in  REG_W  operand 2 register number.
- bank_rd_en  out  NUM_BANKS  per-bank read strobe.
- bank_rd_addr  out  NUM_BANKS*log2(REGS_PER_BANK)  per-bank row address, bank b at slice b.
- bank_rd_data  in  NUM_BANKS*DATA_W  per-bank read data, valid exactly 1 cycle after its strobe.
- out_valid  out  1  operands ready for execute.
- out_ready  in  1  execute accepts the operands.
- out_warp  out  WARP_ID_W  warp number, carried from the request.
- out_op1  out  DATA_W  operand 1; zero if src1 is disabled.
- out_op2  out  DATA_W  operand 2; zero if src2 is disabled.
- conflict_count  out  16  saturating count of bank-conflict cycles.

Behaviour:
- Register mapping: bank = reg[log2(NUM_BANKS)-1:0], row = the remaining upper bits.
- FSM states: IDLE, ISSUE, CAPTURE, OUT.
- req_ready = (state==IDLE). A request is accepted on req_valid && req_ready.
- On accept, latch warp, both enables and both registers, set a pending bit per enabled operand, and clear op1/op2.
  - If neither operand is enabled: go IDLE→OUT.
  - Otherwise: go IDLE→ISSUE.
- ISSUE: assert bank_rd_en/bank_rd_addr for every pending operand whose bank is free this cycle.
  - Same bank, same register: one read serves both operands.
  - Same bank, different register: issue src1 only, hold src2 pending, and increment conflict_count (saturates at 0xFFFF).
  - Next state is always CAPTURE.
- CAPTURE: latch bank_rd_data for the operands issued in the previous cycle and clear their pending bits.
  - Any pending bit still set: go to ISSUE.
  - Otherwise: go to OUT.
- OUT: out_valid=1. On out_ready go to IDLE; otherwise hold.
  - out_warp, out_op1 and out_op2 stay stable while out_valid && !out_ready.
- bank_rd_en is zero in every state except ISSUE. bank_rd_addr is don't-care when its strobe is low and is driven 0.
- Latency, with accept at cycle T:
  - no conflict: out_valid at T+3.
  - one conflict: out_valid at T+5.
  - no operands: out_valid at T+1.
- Back-to-back: the next request is accepted at the earliest one cycle after the out handshake, because req_ready rises on re-entering IDLE.
- Reset values: state=IDLE, req_ready=1 after reset release, out_valid=0, out_warp=0, out_op1=0, out_op2=0, bank_rd_en=0, bank_rd_addr=0, conflict_count=0.
- Reset asserted mid-operation: the in-flight request is dropped, no out handshake occurs, and any returning bank data is ignored.
- req_valid while not ready: ignored. Upstream must hold the request.

Decomposition:
- gpu_pkg holds:
  - the collector state enum;
  - localparams for bank-select and row widths;
  - functions reg_to_bank and reg_to_row.
- gpu_warp and the register file share these.
- One combinational sub-module, gpu_bank_conflict_check, takes both pending operands and returns issue1, issue2, shared and conflict. It keeps the FSM file focused on sequencing.

Test Plan:
- Reset, then src1=r5 and src2=r6 (banks 1 and 2; bank 1 row 1 = 0xAAAA, bank 2 row 1 = 0xBBBB) → out_valid at T+3, op1=0xAAAA, op2=0xBBBB, conflict_count=0.
- src1=r4, src2=r8 (both bank 0, rows 1/2) → two ISSUE cycles, out_valid at T+5, correct operands, conflict_count=1.
- src1=src2=r12 → single bank_rd_en pulse on bank 0, op1=op2=the data read from r12, out_valid at T+3.
- src1_en=0, src2_en=0, warp=7 → out_valid at T+1, op1=op2=0, out_warp=7, no bank strobes.
- Hold out_ready=0 for 4 cycles at OUT → outputs stable and req_ready=0; raising out_ready returns to IDLE and req_ready=1 the next cycle.
- Assert rst_n low during CAPTURE → out_valid=0 and bank_rd_en=0 immediately; after release req_ready=1 and conflict_count=0.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU front-end definitions: operand-collector state encoding and the
// register-number to bank/row mapping used by the warp scheduler and register file.
package gpu_pkg;

  localparam int DEF_NUM_BANKS     = 4;
  localparam int DEF_REGS_PER_BANK = 16;
  localparam int DEF_DATA_W        = 64;
  localparam int DEF_WARP_ID_W     = 5;
  localparam int COLL_BANK_W       = $clog2(DEF_NUM_BANKS);
  localparam int COLL_ROW_W        = $clog2(DEF_REGS_PER_BANK);
  localparam int COLL_REG_W        = COLL_BANK_W + COLL_ROW_W;

  typedef enum logic [1:0] {
    COLL_IDLE    = 2'd0,
    COLL_ISSUE   = 2'd1,
    COLL_CAPTURE = 2'd2,
    COLL_OUT     = 2'd3
  } coll_state_e;

  // Low register bits pick the bank so consecutive registers spread across banks.
  function automatic logic [COLL_BANK_W-1:0] reg_to_bank(input logic [COLL_REG_W-1:0] r);
    return r[COLL_BANK_W-1:0];
  endfunction

  function automatic logic [COLL_ROW_W-1:0] reg_to_row(input logic [COLL_REG_W-1:0] r);
    return r[COLL_REG_W-1:COLL_BANK_W];
  endfunction

endpackage

// File: rtl/gpu_operand_collector_if.sv
// Request, bank-read and operand-output bundle of the operand collector.
// Both req_* and out_* use valid/ready: a transfer happens on a rising clk edge
// where valid && ready; the producer holds its payload stable until that edge.
interface gpu_operand_collector_if #(
  parameter int NUM_BANKS     = 4,
  parameter int REGS_PER_BANK = 16,
  parameter int DATA_W        = 64,
  parameter int WARP_ID_W     = 5
);
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int ROW_W  = $clog2(REGS_PER_BANK);
  localparam int REG_W  = BANK_W + ROW_W;

  logic                        req_valid;
  logic                        req_ready;
  logic [WARP_ID_W-1:0]        req_warp;
  logic                        req_src1_en;
  logic [REG_W-1:0]            req_src1_reg;
  logic                        req_src2_en;
  logic [REG_W-1:0]            req_src2_reg;
  logic [NUM_BANKS-1:0]        bank_rd_en;
  logic [NUM_BANKS*ROW_W-1:0]  bank_rd_addr;
  logic [NUM_BANKS*DATA_W-1:0] bank_rd_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [WARP_ID_W-1:0]        out_warp;
  logic [DATA_W-1:0]           out_op1;
  logic [DATA_W-1:0]           out_op2;
  logic [15:0]                 conflict_count;

  modport master (
    output req_valid, req_warp, req_src1_en, req_src1_reg, req_src2_en, req_src2_reg,
    input  req_ready,
    input  bank_rd_en, bank_rd_addr,
    output bank_rd_data,
    input  out_valid, out_warp, out_op1, out_op2, conflict_count,
    output out_ready
  );

  modport slave (
    input  req_valid, req_warp, req_src1_en, req_src1_reg, req_src2_en, req_src2_reg,
    output req_ready,
    output bank_rd_en, bank_rd_addr,
    input  bank_rd_data,
    output out_valid, out_warp, out_op1, out_op2, conflict_count,
    input  out_ready
  );
endinterface

// File: rtl/gpu_bank_conflict_check.sv
// Decides which pending operands may read their bank this cycle; src1 wins a
// bank clash, and a read of the same register by both operands is shared.
module gpu_bank_conflict_check #(
  parameter int BANK_W = 2,
  parameter int REG_W  = 6
) (
  input  logic             pend1,
  input  logic             pend2,
  input  logic [REG_W-1:0] reg1,
  input  logic [REG_W-1:0] reg2,
  output logic             issue1,
  output logic             issue2,
  output logic             shared,
  output logic             conflict
);
  logic both;
  logic same_bank;

  assign both      = pend1 && pend2;
  assign same_bank = (reg1[BANK_W-1:0] == reg2[BANK_W-1:0]);
  assign shared    = both && (reg1 == reg2);
  assign conflict  = both && same_bank && (reg1 != reg2);
  assign issue1    = pend1;
  assign issue2    = pend2 && !conflict;
endmodule

// File: rtl/gpu_operand_collector.sv
// Reads up to two source operands of one decoded instruction from the banked
// register file, serialising bank clashes, and hands them to execute.
module gpu_operand_collector
  import gpu_pkg::*;
#(
  parameter int NUM_BANKS     = DEF_NUM_BANKS,
  parameter int REGS_PER_BANK = DEF_REGS_PER_BANK,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int WARP_ID_W     = DEF_WARP_ID_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  gpu_operand_collector_if.slave bus,
  output coll_state_e            state_dbg
);
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int ROW_W  = $clog2(REGS_PER_BANK);
  localparam int REG_W  = BANK_W + ROW_W;

  coll_state_e                state_q, state_d;
  logic [WARP_ID_W-1:0]       warp_q;
  logic [REG_W-1:0]           reg1_q, reg2_q;
  logic                       pend1_q, pend2_q, iss1_q, iss2_q;
  logic [DATA_W-1:0]          op1_q, op2_q;
  logic [15:0]                conf_q;
  logic                       issue1, issue2, shared, conflict;
  logic [BANK_W-1:0]          bank1, bank2;
  logic [ROW_W-1:0]           row1, row2;
  logic [DATA_W-1:0]          data1, data2;
  logic [NUM_BANKS-1:0]       rd_en;
  logic [NUM_BANKS*ROW_W-1:0] rd_addr;
  logic                       accept, still_pending;

  assign bank1 = reg1_q[BANK_W-1:0];
  assign bank2 = reg2_q[BANK_W-1:0];
  assign row1  = reg1_q[REG_W-1:BANK_W];
  assign row2  = reg2_q[REG_W-1:BANK_W];
  assign data1 = bus.bank_rd_data[int'(bank1)*DATA_W +: DATA_W];
  assign data2 = bus.bank_rd_data[int'(bank2)*DATA_W +: DATA_W];

  assign accept        = (state_q == COLL_IDLE) && bus.req_valid;
  assign still_pending = (pend1_q && !iss1_q) || (pend2_q && !iss2_q);

  gpu_bank_conflict_check #(.BANK_W(BANK_W), .REG_W(REG_W)) u_conflict (
    .pend1   (pend1_q),
    .pend2   (pend2_q),
    .reg1    (reg1_q),
    .reg2    (reg2_q),
    .issue1  (issue1),
    .issue2  (issue2),
    .shared  (shared),
    .conflict(conflict)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLL_IDLE:    if (bus.req_valid) state_d = (bus.req_src1_en || bus.req_src2_en) ? COLL_ISSUE : COLL_OUT;
      COLL_ISSUE:   state_d = COLL_CAPTURE;
      COLL_CAPTURE: state_d = still_pending ? COLL_ISSUE : COLL_OUT;
      COLL_OUT:     if (bus.out_ready) state_d = COLL_IDLE;
      default:      state_d = COLL_IDLE;
    endcase
  end

  // A shared read sits on bank1 == bank2, so the src1 branch already covers it.
  always_comb begin
    rd_en   = '0;
    rd_addr = '0;
    if (state_q == COLL_ISSUE) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (issue1 && (bank1 == BANK_W'(b))) begin
          rd_en[b]                     = 1'b1;
          rd_addr[b*ROW_W +: ROW_W]    = row1;
        end else if (issue2 && !shared && (bank2 == BANK_W'(b))) begin
          rd_en[b]                     = 1'b1;
          rd_addr[b*ROW_W +: ROW_W]    = row2;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLL_IDLE;
      warp_q  <= '0;
      reg1_q  <= '0;
      reg2_q  <= '0;
      pend1_q <= 1'b0;
      pend2_q <= 1'b0;
      iss1_q  <= 1'b0;
      iss2_q  <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      conf_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        warp_q  <= bus.req_warp;
        reg1_q  <= bus.req_src1_reg;
        reg2_q  <= bus.req_src2_reg;
        pend1_q <= bus.req_src1_en;
        pend2_q <= bus.req_src2_en;
        iss1_q  <= 1'b0;
        iss2_q  <= 1'b0;
        op1_q   <= '0;
        op2_q   <= '0;
      end
      if (state_q == COLL_ISSUE) begin
        iss1_q <= issue1;
        iss2_q <= issue2;
        if (conflict && (conf_q != 16'hFFFF)) conf_q <= conf_q + 16'd1;
      end
      if (state_q == COLL_CAPTURE) begin
        iss1_q <= 1'b0;
        iss2_q <= 1'b0;
        if (iss1_q) begin
          op1_q   <= data1;
          pend1_q <= 1'b0;
        end
        if (iss2_q) begin
          op2_q   <= data2;
          pend2_q <= 1'b0;
        end
      end
    end
  end

  assign bus.req_ready      = (state_q == COLL_IDLE);
  assign bus.bank_rd_en     = rd_en;
  assign bus.bank_rd_addr   = rd_addr;
  assign bus.out_valid      = (state_q == COLL_OUT);
  assign bus.out_warp       = warp_q;
  assign bus.out_op1        = op1_q;
  assign bus.out_op2        = op2_q;
  assign bus.conflict_count = conf_q;
  assign state_dbg          = state_q;
endmodule

// File: tb/tb_gpu_operand_collector.sv
// Bench for gpu_operand_collector: register-file responder, request driver,
// expectation queue built from the operand/latency rules, and per-cycle compare.
module tb_gpu_operand_collector;
  import gpu_pkg::*;

  localparam int NB    = 4;
  localparam int RPB   = 16;
  localparam int DW    = 64;
  localparam int WW    = 5;
  localparam int EXP_W = WW + 2*DW + 4 + 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  coll_state_e state_dbg;

  always #5 clk = ~clk;

  gpu_operand_collector_if #(.NUM_BANKS(NB), .REGS_PER_BANK(RPB), .DATA_W(DW), .WARP_ID_W(WW)) bus ();

  gpu_operand_collector #(.NUM_BANKS(NB), .REGS_PER_BANK(RPB), .DATA_W(DW), .WARP_ID_W(WW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .state_dbg(state_dbg)
  );

  int               cyc = 0;
  logic [DW-1:0]    rf [64];
  logic [EXP_W-1:0] exp_q[$];
  int               acc_q[$];
  int               exp_conf = 0;
  int               n_cmp = 0;
  int               n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file: data appears exactly one cycle after a strobe, garbage otherwise.
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (bus.bank_rd_en[b]) bus.bank_rd_data[b*DW +: DW] <= rf[{bus.bank_rd_addr[b*4 +: 4], 2'(b)}];
      else                   bus.bank_rd_data[b*DW +: DW] <= 64'hDEAD_BEEF_DEAD_BEEF;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [WW-1:0] w, input logic e1, input logic [5:0] r1,
                      input logic e2, input logic [5:0] r2);
    logic [DW-1:0] o1, o2;
    logic [3:0]    lat;
    logic [2:0]    st;
    bit            conf;
    bit            done;
    o1   = e1 ? rf[r1] : '0;
    o2   = e2 ? rf[r2] : '0;
    conf = e1 && e2 && (r1[1:0] == r2[1:0]) && (r1 != r2);
    lat  = (!e1 && !e2) ? 4'd1 : (conf ? 4'd5 : 4'd3);
    st   = (!e1 && !e2) ? 3'd0 : ((e1 && e2 && (r1 != r2)) ? 3'd2 : 3'd1);
    done = 1'b0;
    @(negedge clk);
    bus.req_warp     = w;
    bus.req_src1_en  = e1;
    bus.req_src1_reg = r1;
    bus.req_src2_en  = e2;
    bus.req_src2_reg = r2;
    bus.req_valid    = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      if (bus.req_ready) begin
        exp_q.push_back({w, o1, o2, lat, st});
        acc_q.push_back(cyc);
        if (conf) exp_conf++;
        done = 1'b1;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    if (!done) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_out();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.out_valid) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) check("wait_out_timeout", 64'd0, 64'd1);
  endtask

  task automatic take_out();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("req_ready_after_out", 64'(bus.req_ready), 64'd1);
  endtask

  // Compare process: inputs for the coming edge are settled by negedge+1.
  logic [EXP_W-1:0] cur;
  int               cur_acc;
  bit               in_out = 1'b0;
  int               strobes = 0;

  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      in_out  = 1'b0;
      strobes = 0;
    end else begin
      strobes += $countones(bus.bank_rd_en);
      if (bus.out_valid || bus.req_ready) check("strobe_outside_issue", 64'(bus.bank_rd_en), 64'd0);
      if (bus.out_valid) begin
        check("req_ready_during_out", 64'(bus.req_ready), 64'd0);
        if (!in_out) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out_valid", 64'd1, 64'd0);
          end else begin
            cur     = exp_q.pop_front();
            cur_acc = acc_q.pop_front();
            in_out  = 1'b1;
            check("latency", 64'(cyc - cur_acc), 64'(cur[6:3]));
            check("strobe_count", 64'(strobes), 64'(cur[2:0]));
            check("conflict_count", 64'(bus.conflict_count), 64'(exp_conf));
          end
        end
        if (in_out) begin
          check("out_warp", 64'(bus.out_warp), 64'(cur[EXP_W-1 -: WW]));
          check("out_op1", bus.out_op1, cur[2*DW+6 -: DW]);
          check("out_op2", bus.out_op2, cur[DW+6 -: DW]);
        end
        if (bus.out_ready) begin
          in_out  = 1'b0;
          strobes = 0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  logic [4:0] tw [7] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7};
  logic       te1[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [5:0] tr1[7] = '{6'd5, 6'd4, 6'd0, 6'd7, 6'd9, 6'd0, 6'd63};
  logic       te2[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [5:0] tr2[7] = '{6'd6, 6'd8, 6'd12, 6'd3, 6'd9, 6'd0, 6'd62};

  initial begin
    for (int i = 0; i < 64; i++) rf[i] = {16'hC0DE, 40'h0, 8'(i)};
    rf[5] = 64'hAAAA;
    rf[6] = 64'hBBBB;
    bus.req_valid    = 1'b0;
    bus.req_warp     = '0;
    bus.req_src1_en  = 1'b0;
    bus.req_src1_reg = '0;
    bus.req_src2_en  = 1'b0;
    bus.req_src2_reg = '0;
    bus.out_ready    = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_warp", 64'(bus.out_warp), 64'd0);
    check("rst_out_op1", bus.out_op1, 64'd0);
    check("rst_out_op2", bus.out_op2, 64'd0);
    check("rst_bank_rd_en", 64'(bus.bank_rd_en), 64'd0);
    check("rst_bank_rd_addr", 64'(bus.bank_rd_addr), 64'd0);
    check("rst_conflict_count", 64'(bus.conflict_count), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);

    // r5/r6: different banks
    send(5'd3, 1'b1, 6'd5, 1'b1, 6'd6);
    wait_out();
    check("t1_op1", bus.out_op1, 64'hAAAA);
    check("t1_op2", bus.out_op2, 64'hBBBB);
    check("t1_conf", 64'(bus.conflict_count), 64'd0);
    take_out();

    // r4/r8: bank 0 clash
    send(5'd4, 1'b1, 6'd4, 1'b1, 6'd8);
    wait_out();
    check("t2_op1", bus.out_op1, 64'hC0DE_0000_0000_0004);
    check("t2_op2", bus.out_op2, 64'hC0DE_0000_0000_0008);
    check("t2_conf", 64'(bus.conflict_count), 64'd1);
    take_out();

    // r12 for both operands: one shared read
    send(5'd5, 1'b1, 6'd12, 1'b1, 6'd12);
    wait_out();
    check("t3_op1", bus.out_op1, 64'hC0DE_0000_0000_000C);
    check("t3_op2", bus.out_op2, 64'hC0DE_0000_0000_000C);
    check("t3_conf", 64'(bus.conflict_count), 64'd1);
    take_out();

    // No register operands
    send(5'd7, 1'b0, 6'd0, 1'b0, 6'd0);
    wait_out();
    check("t4_warp", 64'(bus.out_warp), 64'd7);
    check("t4_op1", bus.out_op1, 64'd0);
    check("t4_op2", bus.out_op2, 64'd0);
    take_out();

    // Backpressure at OUT
    send(5'd9, 1'b1, 6'd1, 1'b1, 6'd2);
    wait_out();
    repeat (4) begin
      @(negedge clk);
      check("t5_hold_valid", 64'(bus.out_valid), 64'd1);
      check("t5_hold_op1", bus.out_op1, 64'hC0DE_0000_0000_0001);
      check("t5_hold_op2", bus.out_op2, 64'hC0DE_0000_0000_0002);
      check("t5_hold_req_ready", 64'(bus.req_ready), 64'd0);
    end
    take_out();

    // Reset during CAPTURE
    send(5'd11, 1'b1, 6'd4, 1'b1, 6'd8);
    @(negedge clk);
    check("t6_in_capture", 64'(state_dbg), 64'(COLL_CAPTURE));
    rst_n = 1'b0;
    #1;
    check("t6_out_valid", 64'(bus.out_valid), 64'd0);
    check("t6_bank_rd_en", 64'(bus.bank_rd_en), 64'd0);
    exp_q.delete();
    acc_q.delete();
    exp_conf = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_req_ready", 64'(bus.req_ready), 64'd1);
    check("t6_conf", 64'(bus.conflict_count), 64'd0);
    repeat (3) begin
      @(negedge clk);
      check("t6_no_out", 64'(bus.out_valid), 64'd0);
    end

    // Normal operation resumes after reset
    send(5'd2, 1'b1, 6'd5, 1'b0, 6'd0);
    wait_out();
    check("t7_op1", bus.out_op1, 64'hAAAA);
    check("t7_op2", bus.out_op2, 64'd0);
    check("t7_conf", 64'(bus.conflict_count), 64'd0);
    take_out();

    // Back-to-back table with execute always ready
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) send(tw[i], te1[i], tr1[i], te2[i], tr2[i]);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    check("final_conf", 64'(bus.conflict_count), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
